// File: rtl/rv_isa_pkg.sv
// RV32I constants shared with the main control decoder: class codes, opcodes,
// fixed funct3 values and the canonical NOP.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_JALR = 3'd3,
    CLS_S    = 3'd4,
    CLS_B    = 3'd5,
    CLS_J    = 3'd6,
    CLS_U    = 3'd7
  } instr_class_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  // addi x0,x0,0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_if.sv
// Source-side and sink-side handshake bundle of the instruction encoder,
// plus its status outputs.
interface instr_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [CNT_W-1:0]  instr_count;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output base_load, base_addr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, instr_count, err_count
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  base_load, base_addr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, instr_count, err_count
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Places the immediate bits of each RV32I format into their instruction word
// positions and flags immediates that the format cannot represent.
module imm_pack
  import rv_isa_pkg::*;
(
  input  instr_class_e       cls,
  input  logic signed [31:0] imm,
  output logic        [31:0] imm_bits,
  output logic               range_err
);

  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (imm >= -32'sd2048)    && (imm <= 32'sd2047);
  assign fits13 = (imm >= -32'sd4096)    && (imm <= 32'sd4094);
  assign fits21 = (imm >= -32'sd1048576) && (imm <= 32'sd1048574);

  always_comb begin
    imm_bits  = '0;
    range_err = 1'b0;
    case (cls)
      CLS_I, CLS_LW, CLS_JALR: begin
        imm_bits[31:20] = imm[11:0];
        range_err       = !fits12;
      end
      CLS_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        range_err       = !fits12;
      end
      CLS_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        range_err       = !fits13 || imm[0];
      end
      CLS_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        range_err       = !fits21 || imm[0];
      end
      CLS_U: begin
        imm_bits[31:12] = imm[31:12];
        range_err       = |imm[11:0];
      end
      default: begin
        imm_bits  = '0;
        range_err = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs an instruction class plus fields into an RV32I word, stamps it with an
// auto-incrementing byte address and presents it through a one-deep output stage.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);

  instr_class_e      cls;
  logic [31:0]       imm_bits;
  logic              range_err;
  logic [31:0]       enc_word;
  logic              accept;
  logic              out_hs;
  logic [ADDR_W-1:0] base_al;
  logic [ADDR_W-1:0] word_addr;

  logic              out_valid_q,   out_valid_d;
  logic [31:0]       out_instr_q,   out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,    out_addr_d;
  logic [ADDR_W-1:0] addr_cnt_q,    addr_cnt_d;
  logic              err_q,         err_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic [CNT_W-1:0]  err_count_q,   err_count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cls = instr_class_e'(bus.in_class);

  imm_pack u_imm_pack (
    .cls       (cls),
    .imm       (bus.in_imm),
    .imm_bits  (imm_bits),
    .range_err (range_err)
  );

  always_comb begin
    enc_word = '0;
    case (cls)
      CLS_R:    enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_R};
      CLS_I:    enc_word = {12'b0, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_I} | imm_bits;
      CLS_LW:   enc_word = {12'b0, bus.in_rs1, F3_LW, bus.in_rd, OP_LW} | imm_bits;
      CLS_JALR: enc_word = {12'b0, bus.in_rs1, F3_JALR, bus.in_rd, OP_JALR} | imm_bits;
      CLS_S:    enc_word = {7'b0, bus.in_rs2, bus.in_rs1, bus.in_funct3, 5'b0, OP_S} | imm_bits;
      CLS_B:    enc_word = {7'b0, bus.in_rs2, bus.in_rs1, bus.in_funct3, 5'b0, OP_B} | imm_bits;
      CLS_J:    enc_word = {20'b0, bus.in_rd, OP_J} | imm_bits;
      CLS_U:    enc_word = {20'b0, bus.in_rd, OP_U} | imm_bits;
      default:  enc_word = INSTR_NOP;
    endcase
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = out_valid_q && bus.out_ready;

  // A base load in the same cycle as an accept addresses that word at the new base.
  assign base_al   = bus.base_addr & ~ADDR_W'(3);
  assign word_addr = bus.base_load ? base_al : addr_cnt_q;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_addr_d    = out_addr_q;
    addr_cnt_d    = word_addr;
    err_d         = err_q;
    instr_count_d = instr_count_q;
    err_count_d   = err_count_q;

    if (out_hs) begin
      out_valid_d   = 1'b0;
      instr_count_d = sat_inc(instr_count_q);
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = range_err ? INSTR_NOP : enc_word;
      out_addr_d  = word_addr;
      addr_cnt_d  = word_addr + ADDR_W'(4);
      if (range_err) begin
        err_d       = 1'b1;
        err_count_d = sat_inc(err_count_q);
      end
    end
  end

  // Output stage and bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_addr_q    <= RESET_ADDR;
      addr_cnt_q    <= RESET_ADDR;
      err_q         <= 1'b0;
      instr_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_addr_q    <= out_addr_d;
      addr_cnt_q    <= addr_cnt_d;
      err_q         <= err_d;
      instr_count_q <= instr_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.err         = err_q;
  assign bus.instr_count = instr_count_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed RV32I words plus randomized
// traffic checked against a field-arithmetic reference encoder.
module tb_instr_encoder;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_encoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .RESET_ADDR('0), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_cnt = '0;
  int          m_hs = 0;
  int          m_errs = 0;
  bit          m_err = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          rdy_val = 1'b1;

  logic [6:0]  opc [8] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37};
  logic [31:0] bnd [16] = '{32'hFFFF_F800, 32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F7FF,
                            32'hFFFF_F000, 32'h0000_0FFE, 32'h0000_1000, 32'hFFFF_EFFE,
                            32'hFFF0_0000, 32'h000F_FFFE, 32'h0010_0000, 32'hFFEF_FFFE,
                            32'h1234_5000, 32'hFFFF_F000, 32'h0000_0001, 32'h0000_0000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: immediates split with shifts/masks, ranges as integer bounds.
  function automatic logic [31:0] ref_enc(input req_t r, output bit bad);
    longint      v;
    logic [31:0] u, w, f3, base;
    v    = longint'($signed(r.imm));
    u    = r.imm;
    f3   = (r.cls == 3'd2) ? 32'd2 : (r.cls == 3'd3) ? 32'd0 : 32'(r.f3);
    base = 32'(opc[r.cls]);
    bad  = 1'b0;
    w    = '0;
    case (r.cls)
      3'd0: w = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
                (f3 << 12) | (32'(r.rd) << 7) | base;
      3'd1, 3'd2, 3'd3: begin
        bad = (v < -2048) || (v > 2047);
        w   = ((u & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (f3 << 12) | (32'(r.rd) << 7) | base;
      end
      3'd4: begin
        bad = (v < -2048) || (v > 2047);
        w   = (((u >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
              (f3 << 12) | ((u & 32'h1F) << 7) | base;
      end
      3'd5: begin
        bad = (v < -4096) || (v > 4094) || (u[0] != 1'b0);
        w   = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(r.rs2) << 20) |
              (32'(r.rs1) << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8) |
              (((u >> 11) & 1) << 7) | base;
      end
      3'd6: begin
        bad = (v < -1048576) || (v > 1048574) || (u[0] != 1'b0);
        w   = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
              (((u >> 12) & 32'hFF) << 12) | (32'(r.rd) << 7) | base;
      end
      default: begin
        bad = (u % 4096) != 0;
        w   = (u & 32'hFFFF_F000) | (32'(r.rd) << 7) | base;
      end
    endcase
    return bad ? 32'h0000_0013 : w;
  endfunction

  function automatic req_t mk(input int cls, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7, input logic [31:0] imm);
    req_t r;
    r.cls = 3'(cls); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = imm;
    return r;
  endfunction

  // Presents one word until accepted; use_lit pushes a hand-computed word instead of the model's.
  task automatic send(input req_t r, input logic [31:0] lit, input bit use_lit,
                      input bit bl, input logic [31:0] ba);
    bit          acc = 1'b0;
    bit          bad;
    logic [31:0] w;
    exp_t        e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_class = r.cls; bus.in_rd = r.rd; bus.in_rs1 = r.rs1;
    bus.in_rs2 = r.rs2; bus.in_funct3 = r.f3; bus.in_funct7 = r.f7; bus.in_imm = r.imm;
    bus.base_load = bl; bus.base_addr = ba;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (t == 0 && bl) m_cnt = ba & ~32'd3;
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
      bus.base_load = 1'b0;
    end
    if (acc) begin
      w       = ref_enc(r, bad);
      e.instr = use_lit ? lit : w;
      e.addr  = m_cnt;
      exp_q.push_back(e);
      m_cnt   = m_cnt + 32'd4;
      if (bad) begin
        m_err  = 1'b1;
        m_errs = m_errs + 1;
      end
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.base_load = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    rdy_val = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    #3;
    check({tag, "_err"}, 64'(bus.err), 64'(m_err));
    check({tag, "_err_count"}, 64'(bus.err_count), 64'(m_errs));
    check({tag, "_instr_count"}, 64'(bus.instr_count), 64'(m_hs));
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       return $urandom;
      2:       return bnd[$urandom_range(0, 15)];
      3:       return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      default: return $urandom & 32'hFFFF_F000;
    endcase
  endfunction

  // Sole driver of out_ready.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  // Monitor: every output handshake pops and compares one expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h @%0h, required no output", bus.out_instr, bus.out_addr);
        end else begin
          e = exp_q.pop_front();
          check("out_instr", 64'(bus.out_instr), 64'(e.instr));
          check("out_addr", 64'(bus.out_addr), 64'(e.addr));
        end
        m_hs = m_hs + 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_class = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.base_load = 1'b0; bus.base_addr = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_instr_count", 64'(bus.instr_count), 64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    send(mk(0, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b1, 1'b0, '0);
    send(mk(2, 5, 2, 0, 0, 0, 8), 32'h00812283, 1'b1, 1'b0, '0);
    send(mk(4, 0, 2, 5, 2, 0, 12), 32'h00512623, 1'b1, 1'b0, '0);
    send(mk(5, 0, 1, 2, 0, 0, 32'hFFFF_FFFC), 32'hFE208EE3, 1'b1, 1'b0, '0);
    send(mk(6, 1, 0, 0, 0, 0, 2048), 32'h001000EF, 1'b1, 1'b0, '0);
    send(mk(7, 4, 0, 0, 0, 0, 32'h1234_5000), 32'h12345237, 1'b1, 1'b0, '0);
    drain();
    check_counts("clean");

    send(mk(5, 0, 1, 2, 0, 0, 3), 32'h0000_0013, 1'b1, 1'b0, '0);
    send(mk(0, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b1, 1'b0, '0);
    drain();
    check("berr_err", 64'(bus.err), 64'd1);
    check("berr_err_count", 64'(bus.err_count), 64'd1);

    // Stalled sink: second word waits, first stays stable.
    rdy_val = 1'b0;
    repeat (2) @(negedge clk);
    send(mk(0, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b1, 1'b0, '0);
    fork
      send(mk(2, 5, 2, 0, 0, 0, 8), 32'h00812283, 1'b1, 1'b0, '0);
    join_none
    repeat (3) begin
      @(negedge clk);
      #3;
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_out_instr", 64'(bus.out_instr), 64'h002081B3);
    end
    rdy_val = 1'b1;
    wait fork;
    drain();

    send(mk(1, 7, 6, 0, 0, 0, 32'hFFFF_FFFF), 32'h0, 1'b0, 1'b1, 32'h0000_0102);
    send(mk(1, 7, 6, 0, 0, 0, 5), 32'h0, 1'b0, 1'b0, '0);
    drain();
    check("base_next_cnt", 64'(m_cnt), 64'h108);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req_t r;
      r = mk($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), rand_imm());
      send(r, 32'h0, 1'b0, ($urandom_range(0, 15) == 0), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    drain();
    check_counts("random");

    // Reset with a word pending.
    rdy_val = 1'b0;
    repeat (2) @(negedge clk);
    send(mk(0, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b1, 1'b0, '0);
    @(negedge clk);
    #3;
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("mid_rst_err", 64'(bus.err), 64'd0);
    check("mid_rst_instr_count", 64'(bus.instr_count), 64'd0);
    exp_q.delete();
    m_cnt = '0; m_hs = 0; m_errs = 0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rdy_val = 1'b1;
    send(mk(0, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b1, 1'b0, '0);
    drain();
    check_counts("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
